multiplicador: RTL and testbench

//   Sequential radix-2 Booth multiplier for the mult instruction; the counterpart of the divisor unit.

---
 rtl/multiplicador.sv | 112 +++++++++++
 tb/tb_multiplicador.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/multiplicador.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, 2*WIDTH-bit product in HI/LO.
// Optional feature macro MULT_UNSIGNED_EN adds the Unsigned port for unsigned products.
module multiplicador #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MULT_UNSIGNED_EN
    input  logic             Unsigned,
`endif
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);
    // Accumulator is one bit wider than the operands so -2^(WIDTH-1) cannot overflow.
    localparam int E = WIDTH + 1;
`ifdef MULT_UNSIGNED_EN
    localparam int MW     = E;
    localparam int NSTEPS = WIDTH + 1;
`else
    localparam int MW     = WIDTH;
    localparam int NSTEPS = WIDTH;
`endif
    localparam int PW = E + MW + 1;
    localparam int CW = $clog2(NSTEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;

    state_t          state, state_next;
    logic [E-1:0]    m;
    logic [PW-1:0]   p, p_step;
    logic [E-1:0]    acc;
    logic [CW-1:0]   count;
    logic            uns;
    logic [E-1:0]    a_ext;
    logic [MW-1:0]   b_ext;

    always_comb begin
`ifdef MULT_UNSIGNED_EN
        uns   = Unsigned;
        b_ext = {B[WIDTH-1] & ~uns, B};
`else
        uns   = 1'b0;
        b_ext = B;
`endif
        a_ext = {A[WIDTH-1] & ~uns, A};
    end

    // Booth recoding on the two low bits, then arithmetic shift right by one.
    always_comb begin
        acc = p[PW-1 -: E];
        case (p[1:0])
            2'b01:   acc = acc + m;
            2'b10:   acc = acc - m;
            default: acc = p[PW-1 -: E];
        endcase
        p_step = {acc[E-1], acc, p[PW-E-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (MultCtrl) state_next = RUN;
            RUN:     if (count == CW'(NSTEPS - 1)) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m     <= '0;
            p     <= '0;
            count <= '0;
            HI    <= '0;
            LO    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (MultCtrl) begin
                    m     <= a_ext;
                    p     <= {{E{1'b0}}, b_ext, 1'b0};
                    count <= '0;
                end
                RUN: begin
                    p     <= p_step;
                    count <= count + 1'b1;
                end
                WRITE: begin
                    HI   <= p[2*WIDTH:WIDTH+1];
                    LO   <= p[WIDTH:1];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multiplicador.sv
// Self-checking bench for multiplicador (WIDTH=32): directed and random operands against
// a plain 64-bit arithmetic reference.
module tb_multiplicador;
    localparam int W = 32;
`ifdef MULT_UNSIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         MultCtrl = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic         uns_in = 1'b0;
    logic [W-1:0] HI, LO;
    logic         busy, done;

    int checks = 0;
    int errors = 0;
    logic [63:0] last = '0;
    bit done_seen;

    multiplicador #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .MultCtrl(MultCtrl), .A(A), .B(B),
`ifdef MULT_UNSIGNED_EN
        .Unsigned(uns_in),
`endif
        .HI(HI), .LO(LO), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
        longint sa, sb;
        if (u) return {32'b0, a} * {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start request; returns #1 after the start edge with inputs scrambled.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
        A = a; B = b; uns_in = u; MultCtrl = 1'b1;
        @(posedge clk); #1;
        MultCtrl = 1'b0;
        A = $urandom; B = $urandom; uns_in = $urandom_range(0, 1);
    endtask

    // Wait for done (bounded), checking busy, result hold, latency and product.
    task automatic wait_done(input string tag, input logic [63:0] exp);
        int n = 0;
        bit got = 0;
        while (n < LAT + 5 && !got) begin
            @(posedge clk); #1; n++;
            if (n == 1) check({tag, "_busy"}, {63'b0, busy}, 64'd1);
            if (n == LAT / 2) check({tag, "_hold"}, {HI, LO}, last);
            if (n == LAT / 2 + 1) begin
                MultCtrl = 1'b1;    // ignored while running
                @(posedge clk); #1; n++;
                MultCtrl = 1'b0;
            end
            if (done) got = 1;
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_prod"}, {HI, LO}, exp);
        last = exp;
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
        launch(a, b, u);
        wait_done(tag, ref_mul(a, b, u));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        // Reset and idle
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_state", {HI, LO, 62'b0, busy, done}, '0);
        done_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || busy) done_seen = 1;
        end
        check("idle_quiet", {63'b0, done_seen}, 64'd0);
        check("idle_hilo", {HI, LO}, 64'd0);

        run("p3x5", 32'd3, 32'd5, 1'b0);
        check("p3x5_val", {HI, LO}, 64'h0000_0000_0000_000F);
        @(posedge clk); #1;
        check("done_pulse", {63'b0, done}, 64'd0);
        run("neg1x1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("neg1x1_val", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
        run("minxmin", 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("minxmin_val", {HI, LO}, 64'h4000_0000_0000_0000);
        run("maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        check("maxxmax_val", {HI, LO}, 64'h3FFF_FFFF_0000_0001);

        // Abort by reset mid-run; the edge-4 start is ignored
        launch(32'd7, 32'd9, 1'b0);
        done_seen = 0;
        for (int e = 1; e <= 10; e++) begin
            if (e == 4) begin A = 32'd2; B = 32'd2; MultCtrl = 1'b1; end
            if (e == 10) reset = 1'b1;
            @(posedge clk); #1;
            MultCtrl = 1'b0;
            if (done) done_seen = 1;
        end
        reset = 1'b0;
        check("abort_state", {HI, LO, 62'b0, busy, done}, '0);
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (done) done_seen = 1;
        end
        check("abort_nodone", {63'b0, done_seen}, 64'd0);
        last = '0;
        run("after_abort", 32'd2, 32'd2, 1'b0);
        check("after_abort_val", {HI, LO}, 64'd4);

        // Reset wins over a simultaneous start
        reset = 1'b1; MultCtrl = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; MultCtrl = 1'b0;
        check("rst_vs_start", {HI, LO, 62'b0, busy, done}, '0);
        last = '0;

        // Back-to-back: restart in the done cycle
        run("b2b_first", 32'd11, 32'd13, 1'b0);
        run("b2b_second", 32'hFFFF_FFFA, 32'd7, 1'b0);
        check("b2b_val", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFD6);

        // Random operands, occasional idle gaps
        for (int i = 0; i < 10; i++) begin
            ra = $urandom; rb = $urandom;
            if (i == 3) ra = 32'h8000_0000;
            if (i == 4) rb = 32'h8000_0000;
            run("rand", ra, rb, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        repeat (20) @(posedge clk);
        #1;
        check("hold_idle", {HI, LO}, last);

`ifdef MULT_UNSIGNED_EN
        run("u_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("u_ones_val", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        run("s_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("s_ones_val", {HI, LO}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            run("u_rand", ra, rb, 1'b1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
